cnt_shift_ctrl: RTL and testbench
=================================

// Module: cnt_shift_ctrl
// PURPOSE
//   Moore FSM that sequences the cnt_shift datapath as a serial frame receiver.
//   - Waits for a start level on the serial line, then presets the counter and initialises the shift register.
//   - Enables shifting until the counter carry-out marks end of frame.
//   - Captures the 8-bit parallel word and hands it off with a valid/ready handshake.
//   - A watchdog aborts frames whose carry-out never arrives.
// PARAMETERS
//   DW        8    frame width; must match cnt_shift PO_sh width
//   TIMEOUT   16   max SHIFT-state cycles before abort (>=2)
//   WDW       5    watchdog counter width; 2**WDW > TIMEOUT
// PORTS
//   clk        in   1    system clock, rising edge
//   rst        in   1    synchronous active-low reset
//   si_line    in   1    serial line (same net as cnt_shift si); idle 0, start level 1
//   co         in   1    cnt_shift counter carry-out
//   PO_sh      in   DW   cnt_shift parallel output
//   data_ready in   1    consumer accepts data_out
//   rst_sh     out  1    shift register reset, active-high
//   rst_cnt    out  1    counter reset, active-high
//   init_sh    out  1    shift register init
//   ld         out  1    counter preset load
//   en_sh      out  1    shift enable
//   en_cnt     out  1    count enable
//   ci         out  1    counter carry-in
//   data_out   out  DW   captured frame
//   data_valid out  1    data_out valid
//   busy       out  1    frame in progress (state != IDLE)
//   err_to     out  1    watchdog abort, 1-cycle pulse
//   overrun    out  1    sticky: start level seen while in HOLD
// BEHAVIOUR
//   Reset (rst==0 at posedge):
//     - state=IDLE, wd=0, data_out=0, data_valid=0, err_to=0, overrun=0.
//     - rst_sh=rst_cnt=1 while rst==0; every other control output 0.
//   States and control outputs (decoded from state only; unlisted outputs 0):
//     IDLE   all controls 0; si_line==1 -> ARM.
//     ARM    ld=1, init_sh=1; 1 cycle -> SHIFT; wd<=0.
//     SHIFT  en_sh=1, en_cnt=1, ci=1; wd<=wd+1 each cycle.
//            co==1 -> CAPT.
//            else wd==TIMEOUT-1 -> ABORT.
//            If co and timeout coincide, co wins.
//     CAPT   all controls 0; data_out<=PO_sh, data_valid<=1 -> HOLD.
//     HOLD   datapath frozen (en_sh=en_cnt=0).
//            data_out/data_valid held stable.
//            data_valid&&data_ready at posedge -> data_valid<=0, IDLE.
//            si_line==1 here -> overrun<=1 (sticky until reset); frame ignored.
//     ABORT  rst_sh=1, rst_cnt=1, err_to=1 for exactly 1 cycle -> IDLE; data_valid unchanged (0).
//   Timing and latency:
//     - Start detect to first shift enable: 2 cycles (IDLE->ARM->SHIFT).
//     - co sampled -> data_valid high 2 edges later (SHIFT->CAPT at edge 1, data_valid<=1 at edge 2 while CAPT->HOLD).
//     - Back-to-back frames: earliest new ARM is 1 cycle after handshake (via IDLE).
//   Reset mid-frame: any state -> IDLE next edge; datapath reset via rst_sh/rst_cnt; partial frame discarded.
//   wd saturates at TIMEOUT-1 and never wraps.
// TESTING
//   1. Hold rst=0 2 cycles -> rst_sh=rst_cnt=1, data_valid=0, busy=0; release -> all controls 0.
//   2. si_line=1 one cycle; model co after 8 SHIFT cycles with PO_sh=8'hA5; data_ready=1
//      -> ld/init_sh pulse 1 cycle, en_sh high 8 cycles, data_out=8'hA5, data_valid 1 cycle.
//   3. Same frame with data_ready=0 for 5 cycles -> data_valid and data_out=8'hA5 stable 5 cycles;
//      si_line=1 during hold -> overrun=1; clears only on reset.
//   4. Start frame, never assert co -> err_to pulse after exactly TIMEOUT=16 SHIFT cycles,
//      rst_sh=rst_cnt=1 that cycle, then IDLE, data_valid stays 0.
//   5. Assert co in SHIFT cycle 16 (timeout cycle) with PO_sh=8'h3C -> CAPT taken, err_to=0, data_out=8'h3C.
//   6. rst=0 in SHIFT cycle 4 -> IDLE next edge, busy=0, no data_valid; next start produces a clean frame.

Source files
------------

// File: rtl/cnt_shift_ctrl_if.sv
// ----------------------------------------------------------------------------
// cnt_shift_ctrl_if
//   Output handshake of the serial frame receiver.
//   master : frame producer (drives data_out/data_valid, samples data_ready)
//   slave  : frame consumer (samples data_out/data_valid, drives data_ready)
//   DW must match the DW of the cnt_shift_ctrl instance it is bound to.
// ----------------------------------------------------------------------------
interface cnt_shift_ctrl_if #(
    parameter int DW = 8
);
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/cnt_shift_ctrl.sv
// ----------------------------------------------------------------------------
// cnt_shift_ctrl
//   Moore FSM sequencing the cnt_shift datapath as a serial frame receiver.
//   A start level on si_line presets the counter and initialises the shift
//   register, shifting runs until the counter carry-out, the parallel word is
//   captured and offered on a valid/ready handshake. A watchdog aborts frames
//   whose carry-out never arrives.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active low
//   si_line    in   serial line (idle 0, start level 1)
//   co         in   datapath counter carry-out
//   PO_sh      in   datapath parallel output [DW]
//   rst_sh     out  shift register reset (active high)
//   rst_cnt    out  counter reset (active high)
//   init_sh    out  shift register init
//   ld         out  counter preset load
//   en_sh      out  shift enable
//   en_cnt     out  count enable
//   ci         out  counter carry-in
//   busy       out  frame in progress
//   err_to     out  watchdog abort, one-cycle pulse
//   overrun    out  sticky: start level seen while holding a word
//   hs         if   master side of data_out/data_valid/data_ready
// ----------------------------------------------------------------------------
module cnt_shift_ctrl #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 16,
    parameter int WDW     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          si_line,
    input  logic          co,
    input  logic [DW-1:0] PO_sh,
    output logic          rst_sh,
    output logic          rst_cnt,
    output logic          init_sh,
    output logic          ld,
    output logic          en_sh,
    output logic          en_cnt,
    output logic          ci,
    output logic          busy,
    output logic          err_to,
    output logic          overrun,
    cnt_shift_ctrl_if.master hs
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        SHIFT = 3'd2,
        CAPT  = 3'd3,
        HOLD  = 3'd4,
        ABORT = 3'd5
    } state_t;

    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    state_t        state_q;
    logic [WDW-1:0] wd_q;
    logic [WDW-1:0] wd_d;
    logic [DW-1:0] data_q;
    logic          valid_q;
    logic          ovr_q;

    // Watchdog saturates so a long SHIFT can never wrap back below the limit.
    assign wd_d = (wd_q == WD_LAST) ? wd_q : wd_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            wd_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (si_line) state_q <= ARM;
                end
                ARM: begin
                    wd_q    <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    wd_q <= wd_d;
                    // Carry-out has priority over a coincident timeout.
                    if (co)                   state_q <= CAPT;
                    else if (wd_q == WD_LAST) state_q <= ABORT;
                end
                CAPT: begin
                    // Final shift lands on the edge leaving SHIFT, so the
                    // complete word is on PO_sh during CAPT.
                    data_q  <= PO_sh;
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (si_line) ovr_q <= 1'b1;
                    if (valid_q && hs.data_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ABORT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Controls decode from state only; while rst is low the datapath is held
    // in reset and every other control is forced low.
    assign rst_sh  = !rst || (state_q == ABORT);
    assign rst_cnt = !rst || (state_q == ABORT);
    assign init_sh = rst && (state_q == ARM);
    assign ld      = rst && (state_q == ARM);
    assign en_sh   = rst && (state_q == SHIFT);
    assign en_cnt  = rst && (state_q == SHIFT);
    assign ci      = rst && (state_q == SHIFT);
    assign err_to  = rst && (state_q == ABORT);
    assign busy    = rst && (state_q != IDLE);
    assign overrun = ovr_q;

    assign hs.data_out   = data_q;
    assign hs.data_valid = valid_q;

endmodule

// File: tb/tb_cnt_shift_ctrl.sv
module tb_cnt_shift_ctrl;

    localparam int DW      = 8;
    localparam int TIMEOUT = 16;
    localparam int WDW     = 5;
    localparam logic [8:0] ABORT_TAG = 9'h100;

    logic          clk = 1'b0;
    logic          rst;
    logic          si_line;
    logic          co;
    logic [DW-1:0] PO_sh;
    logic          rst_sh, rst_cnt, init_sh, ld, en_sh, en_cnt, ci;
    logic          busy, err_to, overrun;

    int n_vec = 0;
    int n_err = 0;

    // Expected hand-offs: {0,word} for a captured frame, ABORT_TAG for a timeout.
    logic [8:0] sb_q[$];

    cnt_shift_ctrl_if #(.DW(DW)) hs ();

    cnt_shift_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT), .WDW(WDW)) dut (
        .clk     (clk),
        .rst     (rst),
        .si_line (si_line),
        .co      (co),
        .PO_sh   (PO_sh),
        .rst_sh  (rst_sh),
        .rst_cnt (rst_cnt),
        .init_sh (init_sh),
        .ld      (ld),
        .en_sh   (en_sh),
        .en_cnt  (en_cnt),
        .ci      (ci),
        .busy    (busy),
        .err_to  (err_to),
        .overrun (overrun),
        .hs      (hs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: one pop per observed handshake or abort pulse.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (hs.data_valid === 1'b1 && hs.data_ready === 1'b1) begin
                if (sb_q.size() == 0) chk("sb_unexpected_data", 32'(hs.data_out), 32'hFFFF);
                else                  chk("sb_data", {23'd0, 1'b0, hs.data_out}, 32'(sb_q.pop_front()));
            end
            if (err_to === 1'b1) begin
                if (sb_q.size() == 0) chk("sb_unexpected_abort", 32'(ABORT_TAG), 32'hFFFF);
                else                  chk("sb_abort", 32'(ABORT_TAG), 32'(sb_q.pop_front()));
            end
        end
    end

    // Start a frame and check the one-cycle ARM pulse; returns in SHIFT cycle 1.
    task automatic start_frame();
        si_line = 1'b1;
        tick();
        chk("arm_ld", ld, 1);
        chk("arm_init", init_sh, 1);
        chk("arm_en_sh", en_sh, 0);
        chk("arm_busy", busy, 1);
        si_line = 1'b0;
        tick();
    endtask

    // Full frame: co in SHIFT cycle nshift, word d, consumer stalls hold_cyc
    // cycles, optional start level poked during the stall.
    task automatic run_frame(input logic [7:0] d, input int nshift,
                             input int hold_cyc, input bit poke);
        sb_q.push_back({1'b0, d});
        PO_sh = ~d;
        start_frame();
        for (int i = 1; i <= nshift; i++) begin
            if (i == 1) chk("shift_ld_off", ld, 0);
            chk("shift_en_sh", en_sh, 1);
            chk("shift_en_cnt", en_cnt, 1);
            chk("shift_ci", ci, 1);
            chk("shift_err", err_to, 0);
            co = (i == nshift);
            tick();
        end
        co    = 1'b0;
        PO_sh = d;
        chk("capt_en_sh", en_sh, 0);
        chk("capt_err", err_to, 0);
        chk("capt_vld", hs.data_valid, 0);
        chk("capt_busy", busy, 1);
        hs.data_ready = 1'b0;
        tick();
        PO_sh = 8'h00;
        for (int h = 0; h < hold_cyc; h++) begin
            chk("hold_vld", hs.data_valid, 1);
            chk("hold_data", hs.data_out, 32'(d));
            chk("hold_en_sh", en_sh, 0);
            si_line = poke && (h == 1);
            tick();
        end
        si_line = 1'b0;
        hs.data_ready = 1'b1;
        chk("hs_vld", hs.data_valid, 1);
        chk("hs_data", hs.data_out, 32'(d));
        tick();
        hs.data_ready = 1'b0;
        chk("post_vld", hs.data_valid, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL tb_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b0; si_line = 1'b0; co = 1'b0; PO_sh = '0; hs.data_ready = 1'b0;

        // 1: reset state
        tick(); tick();
        chk("rst_rst_sh", rst_sh, 1);
        chk("rst_rst_cnt", rst_cnt, 1);
        chk("rst_vld", hs.data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_en_sh", en_sh, 0);
        chk("rst_ovr", overrun, 0);
        rst = 1'b1;
        tick();
        chk("idle_ctl", {rst_sh, rst_cnt, init_sh, ld, en_sh, en_cnt, ci, err_to, busy}, 0);
        chk("idle_data", hs.data_out, 0);

        // 2: basic frame, consumer ready at once
        run_frame(8'hA5, 8, 0, 1'b0);

        // 3: consumer stalls 5 cycles, start level during hold
        run_frame(8'hA5, 8, 5, 1'b1);
        chk("ovr_set", overrun, 1);
        tick();
        chk("ovr_ignored_busy", busy, 0);

        // 4: carry-out never arrives
        sb_q.push_back(ABORT_TAG);
        start_frame();
        for (int i = 1; i <= TIMEOUT; i++) begin
            chk("wd_en_sh", en_sh, 1);
            chk("wd_err", err_to, 0);
            tick();
        end
        chk("abort_err", err_to, 1);
        chk("abort_rst_sh", rst_sh, 1);
        chk("abort_rst_cnt", rst_cnt, 1);
        chk("abort_en_sh", en_sh, 0);
        chk("abort_vld", hs.data_valid, 0);
        tick();
        chk("post_abort_err", err_to, 0);
        chk("post_abort_busy", busy, 0);
        chk("post_abort_rst_sh", rst_sh, 0);
        chk("post_abort_vld", hs.data_valid, 0);
        chk("ovr_sticky", overrun, 1);

        // 5: carry-out in the timeout cycle wins
        run_frame(8'h3C, TIMEOUT, 0, 1'b0);

        // 6: reset in SHIFT cycle 4, then a clean frame
        start_frame();
        tick(); tick(); tick();
        chk("mid_en_sh", en_sh, 1);
        rst = 1'b0;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rst_sh", rst_sh, 1);
        chk("mid_rst_en_sh", en_sh, 0);
        chk("mid_rst_vld", hs.data_valid, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_ovr_clr", overrun, 0);
        chk("mid_rst_idle", busy, 0);
        run_frame(8'h5A, 8, 2, 1'b0);
        chk("final_ovr", overrun, 0);

        tick();
        chk("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
